// File: rtl/dmem_arb_pkg.sv
// Shared types and peripheral map for the data-memory arbiter.
// Peripheral addresses are exported for benches and neighbouring blocks.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCK0,
    LOCK1
  } arb_state_t;

  localparam logic [31:0] SW_ADDR     = 32'hC000_0000;
  localparam logic [31:0] LED_ADDR    = 32'hC000_0004;
  localparam logic [31:0] DISP_ADDR   = 32'hC000_0008;
  localparam logic [31:0] LETTER_ADDR = 32'hC000_000C;
  localparam logic [31:0] PB_ADDR     = 32'hC000_0010;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker, purely combinational.
// last=1 means master 0 wins a tie, last=0 means master 1 does.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory port.
// Round-robin with a bounded lock for read-modify-write sequences.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam logic [3:0] LMAX     = 4'(MAX_LOCK);
  localparam bit         CAN_LOCK = (MAX_LOCK > 1);

  arb_state_t    r_state;
  logic          r_last;
  logic [3:0]    r_lock_cnt;
  logic [1:0]    r_rvalid;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic [1:0] w_rr_gnt;
  logic [1:0] w_gnt;
  logic       w_sel1;
  logic       w_any;
  logic       w_win_we;
  logic       w_win_lock;
  logic       w_own_req;
  logic       w_own_lock;
  logic [3:0] w_cnt_nxt;
  logic       w_cnt_max;
  logic       w_rd0;
  logic       w_rd1;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (r_last),
    .gnt  (w_rr_gnt)
  );

  always_comb begin
    w_gnt = 2'b00;
    case (r_state)
      UNLOCKED: w_gnt = w_rr_gnt;
      LOCK0:    w_gnt = {1'b0, m0_req};
      LOCK1:    w_gnt = {m1_req, 1'b0};
      default:  w_gnt = 2'b00;
    endcase
  end

  // With no grant the port idles on master 0's inputs.
  assign w_sel1     = w_gnt[1];
  assign w_any      = |w_gnt;
  assign w_win_we   = w_sel1 ? m1_we : m0_we;
  assign w_win_lock = w_sel1 ? m1_lock : m0_lock;

  assign mem_we = w_win_we & w_any;
  assign mem_a  = w_sel1 ? m1_addr : m0_addr;
  assign mem_wd = w_sel1 ? m1_wdata : m0_wdata;

  assign w_own_req  = (r_state == LOCK1) ? m1_req : m0_req;
  assign w_own_lock = (r_state == LOCK1) ? m1_lock : m0_lock;
  assign w_cnt_nxt  = r_lock_cnt + 4'd1;
  assign w_cnt_max  = (w_cnt_nxt == LMAX);

  assign w_rd0 = w_gnt[0] & ~m0_we;
  assign w_rd1 = w_gnt[1] & ~m1_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= UNLOCKED;
      r_last     <= 1'b1;
      r_lock_cnt <= 4'd0;
      r_rvalid   <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_rvalid <= {w_rd1, w_rd0};
      if (w_rd0) r_rdata0 <= mem_rd;
      if (w_rd1) r_rdata1 <= mem_rd;
      if (w_any) r_last <= w_sel1;
      case (r_state)
        UNLOCKED: begin
          if (w_any && w_win_lock && CAN_LOCK) begin
            r_state    <= w_sel1 ? LOCK1 : LOCK0;
            r_lock_cnt <= 4'd1;
          end
        end
        LOCK0, LOCK1: begin
          // Forced release at MAX_LOCK hands the next tie to the other master.
          if (w_own_req && w_own_lock && !w_cnt_max) begin
            r_lock_cnt <= w_cnt_nxt;
          end else begin
            r_state    <= UNLOCKED;
            r_lock_cnt <= 4'd0;
          end
        end
        default: begin
          r_state    <= UNLOCKED;
          r_lock_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (RAM array plus memory-mapped switches, PB, LEDs and displays at 0xC000_0000–0xC000_0010) between two masters.
- Master 0 is the ARM core data port. Master 1 is a second agent, e.g. the program/data loader or a debug port.
- Arbitration is round-robin, with an optional bounded lock for read-modify-write sequences.
- The block sits between the masters and the memory's we/a/wd/rd port.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_LOCK, 4, maximum consecutive locked grants to one master (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 requests an access this cycle
- m0_we  in  1  master 0 write enable
- m0_lock  in  1  master 0 requests to keep ownership after this access
- m0_addr  in  AW  master 0 byte address
- m0_wdata  in  DW  master 0 write data
- m0_gnt  out  1  master 0 access is performed this cycle
- m0_rvalid  out  1  read data for master 0 is valid (one cycle after its read grant)
- m0_rdata  out  DW  registered read data for master 0
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- mem_we  out  1  write enable to memory
- mem_a  out  AW  address to memory
- mem_wd  out  DW  write data to memory
- mem_rd  in  DW  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it takes effect only at the clk rising edge.
- Reset state: state=UNLOCKED, last=1 (master 0 wins the first tie), lock_cnt=0, all gnt/rvalid=0, rdata=0.
- Access timing: one access per cycle. The winner is chosen combinationally each cycle.
  - gnt is asserted in the same cycle as the access.
  - mem_we/mem_a/mem_wd are muxed combinationally from the winner.
  - mem_we = winner_we & winner_gnt.
  - With no grant, mem_we=0 and mem_a/mem_wd are held at master 0's inputs.
- Write timing: a write completes at the clk edge ending the grant cycle.
- Read timing: for a granted read (we=0), mem_rd is captured into that master's rdata at the clk edge ending the grant cycle. rvalid pulses high for exactly one cycle after that edge.
  - rdata holds its value until the master's next read.
  - rvalid=0 after a write grant.
- States:
  - UNLOCKED: arbitration is round-robin.
    - Only one master requesting: it wins.
    - Both requesting: the master not equal to last wins.
    - On every grant, last <= winner.
    - If the winner has lock=1 in its grant cycle: state <= LOCK0 or LOCK1, lock_cnt <= 1.
  - LOCKx: only master x may be granted; the other master's req is ignored (its gnt=0).
    - If x_req & x_lock: grant x and lock_cnt++.
      - When lock_cnt reaches MAX_LOCK on this grant, state <= UNLOCKED and last <= x. The other master then wins any tie.
    - If x_req & !x_lock: grant x (the final locked access), then state <= UNLOCKED.
    - If !x_req: no grant; state <= UNLOCKED the same edge. The other master is not granted in this cycle.
- Boundaries:
  - Both masters idle: no grant, last unchanged.
  - Lock asserted without req: no effect.
  - After a MAX_LOCK forced release, a lock still asserted by x is honoured again only after a grant to x from UNLOCKED; round-robin gives the other master one turn first if it is requesting.
  - reset mid-lock: back to UNLOCKED in the same edge, and any pending rvalid is suppressed.
- Address checking: addresses are passed through unmodified. Peripheral decoding and alignment checking remain the memory's job.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} arb_state_t
  - localparam peripheral addresses SW_ADDR=0xC000_0000, LED_ADDR=0xC000_0004, DISP_ADDR=0xC000_0008, LETTER_ADDR=0xC000_000C, PB_ADDR=0xC000_0010, for benches and other blocks.
- One sub-module, rr_pick2: a two-input round-robin picker with inputs req[1:0] and last, and outputs gnt[1:0]. It is purely combinational and instantiated once.
- The state register, lock counter and read-data registers live in the top level.

Test Plan:
- Single master: m0 writes 0x0000_00AA to addr 0x10, then reads addr 0x10 -> m0_gnt=1 both cycles; mem_we=1 only on the write; m0_rvalid=1 in the cycle after the read with m0_rdata=0x0000_00AA; m1_gnt=0 throughout.
- Contention right after reset: m0 and m1 both request reads continuously -> grants alternate m0, m1, m0, m1; each rvalid pulses one cycle after its own grant.
- Lock: m1 issues read(0x20) with lock=1, then write(0x20, 0x55) with lock=0, while m0 requests continuously -> m1 is granted 2 consecutive cycles and m0 waits; m0 is granted in the 3rd cycle.
- Forced release: m0 holds req=1 and lock=1 for 8 cycles with MAX_LOCK=4, m1 requesting -> m0 granted 4 cycles, m1 granted cycle 5, m0 granted cycle 6.
- Peripheral passthrough: m1 writes 0x3FF to LED_ADDR, m0 reads SW_ADDR with mem_rd=0x0000_0155 -> mem_a follows the winner each cycle; mem_we is high for exactly 1 cycle; m0_rdata=0x155.
- Reset mid-lock: assert reset during LOCK0 with a read granted in the same cycle -> next cycle state=UNLOCKED, m0_rvalid=0, m0_rdata=0; a subsequent m1 request is granted immediately.
